// File: rtl/segway_mtr_pkg.sv
// segway_mtr_pkg: shared widths, timing constants and duty conversion for the motor driver
package segway_mtr_pkg;
  localparam int PWM_W = 11;
  localparam int NONOVERLAP = 32;
  localparam int BLANK = 128;
  localparam int OVR_LIMIT = 32;
  typedef logic [PWM_W-1:0] duty_t;
  typedef enum logic {DEAD, DRIVE} nonovlp_state_t;
  localparam duty_t DUTY_MID = duty_t'(2**(PWM_W-1));
  // Halving the signed speed and offsetting by mid-scale maps full reverse..forward onto 0..max duty.
  function automatic duty_t spd2duty(input logic signed [11:0] spd);
    logic signed [11:0] h;
    h = spd >>> 1;
    return h[PWM_W-1:0] + DUTY_MID;
  endfunction
endpackage

// File: rtl/segway_pwm_nonovlp.sv
// segway_pwm_nonovlp: turns one PWM signal into a dead-time separated high/low gate pair
module segway_pwm_nonovlp
  import segway_mtr_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pwm_sig,
  input  logic kill,
  output logic PWM1,
  output logic PWM2,
  output logic hi_rise
);
  localparam int DW = $clog2(NONOVERLAP);
  nonovlp_state_t state, state_nxt;
  logic tgt;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic chg;
  assign chg = pwm_sig != tgt;
  always_comb begin
    state_nxt = chg ? DEAD : (state == DEAD && dcnt == DW'(NONOVERLAP-1)) ? DRIVE : state;
    dcnt_nxt = chg ? '0 : (state == DEAD && dcnt != DW'(NONOVERLAP-1)) ? dcnt + DW'(1) : dcnt;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= DEAD;
      tgt <= 1'b0;
      dcnt <= '0;
      PWM1 <= 1'b0;
      PWM2 <= 1'b0;
      hi_rise <= 1'b0;
    end else begin
      state <= state_nxt;
      tgt <= pwm_sig;
      dcnt <= dcnt_nxt;
      PWM1 <= ~kill & (state == DRIVE) & tgt;
      PWM2 <= ~kill & (state == DRIVE) & ~tgt;
      hi_rise <= ~kill & (state == DRIVE) & tgt & ~PWM1;
    end
endmodule

// File: rtl/segway_mtr_drv.sv
// segway_mtr_drv: dual H-bridge PWM driver with dead time; SEGWAY_MTR_OVR_I_EN adds over-current shutdown
module segway_mtr_drv
  import segway_mtr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        OVR_I_lft,
  input  logic        OVR_I_rght,
  output logic        PWM1_lft,
  output logic        PWM2_lft,
  output logic        PWM1_rght,
  output logic        PWM2_rght,
  output logic        OVR_I_shtdwn
);
  logic [PWM_W-1:0] cnt;
  duty_t duty_l, duty_r;
  logic sig_l, sig_r, kill, rise_l, rise_r;
  // Duty is only reloaded on the last count so a period never changes mid-way.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      duty_l <= DUTY_MID;
      duty_r <= DUTY_MID;
      sig_l <= 1'b0;
      sig_r <= 1'b0;
    end else begin
      cnt <= cnt + PWM_W'(1);
      if (&cnt) begin
        duty_l <= spd2duty(lft_spd);
        duty_r <= spd2duty(rght_spd);
      end
      sig_l <= cnt < duty_l;
      sig_r <= cnt < duty_r;
    end
  segway_pwm_nonovlp u_lft (.clk(clk), .rst(rst), .pwm_sig(sig_l), .kill(kill),
                            .PWM1(PWM1_lft), .PWM2(PWM2_lft), .hi_rise(rise_l));
  segway_pwm_nonovlp u_rght (.clk(clk), .rst(rst), .pwm_sig(sig_r), .kill(kill),
                             .PWM1(PWM1_rght), .PWM2(PWM2_rght), .hi_rise(rise_r));
`ifdef SEGWAY_MTR_OVR_I_EN
  localparam int BW = $clog2(BLANK+1);
  localparam int OW = $clog2(OVR_LIMIT+1);
  logic [1:0] sync_l, sync_r;
  logic [BW-1:0] blank_l, blank_r;
  logic [OW-1:0] ovr_cnt;
  logic period_flt, flt_now;
  // The rise cycle itself still sees last period's saturated blank count, so it is excluded.
  assign flt_now = (sync_l[1] & PWM1_lft & ~rise_l & (blank_l >= BW'(BLANK))) |
                   (sync_r[1] & PWM1_rght & ~rise_r & (blank_r >= BW'(BLANK)));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_l <= '0;
      sync_r <= '0;
      blank_l <= '0;
      blank_r <= '0;
      ovr_cnt <= '0;
      period_flt <= 1'b0;
      OVR_I_shtdwn <= 1'b0;
    end else begin
      sync_l <= {sync_l[0], OVR_I_lft};
      sync_r <= {sync_r[0], OVR_I_rght};
      blank_l <= rise_l ? '0 : (blank_l == BW'(BLANK)) ? blank_l : blank_l + BW'(1);
      blank_r <= rise_r ? '0 : (blank_r == BW'(BLANK)) ? blank_r : blank_r + BW'(1);
      period_flt <= (&cnt) ? 1'b0 : period_flt | flt_now;
      if (&cnt)
        ovr_cnt <= ~(period_flt | flt_now) ? '0 :
                   (ovr_cnt == OW'(OVR_LIMIT)) ? ovr_cnt : ovr_cnt + OW'(1);
      OVR_I_shtdwn <= OVR_I_shtdwn | (ovr_cnt == OW'(OVR_LIMIT));
    end
  assign kill = OVR_I_shtdwn;
`else
  logic unused_ovr;
  assign unused_ovr = OVR_I_lft ^ OVR_I_rght ^ rise_l ^ rise_r;
  assign OVR_I_shtdwn = 1'b0;
  assign kill = 1'b0;
`endif
endmodule
